bit_serial_add_ctrl: RTL and testbench

- Sequencer that time-multiplexes one 1-bit full_adder cell over a multi-bit add, LSB first, with a registered carry.
- Precision is configurable per operation, in the bit-flexible datapath style.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Used where area matters more than throughput: control-path accumulation and low-rate reductions.

---
 rtl/bit_serial_add_ctrl_pkg.sv | 15 +
 rtl/full_adder.sv | 13 +
 rtl/bit_serial_add_ctrl.sv | 118 +++++++++++
 tb/tb_bit_serial_add_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/bit_serial_add_ctrl_pkg.sv
// Shared state encoding and width helper for the bit-serial adder controller.
package bit_serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } bsa_state_e;

    // Counter / cfg width: must hold the value DATA_WIDTH itself.
    function automatic int bsa_cnt_w(input int data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder; the single arithmetic cell reused every cycle by the serial adder.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial n-bit adder: one full_adder stepped LSB first with a registered carry.
// Optional signed-overflow output enabled by defining BIT_SERIAL_ADD_OVERFLOW_EN.
module bit_serial_add_ctrl
    import bit_serial_add_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_W      = bsa_cnt_w(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  in_cin,
    input  logic [CNT_W-1:0]      cfg_bits,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_sum,
    output logic                  out_carry
`ifdef BIT_SERIAL_ADD_OVERFLOW_EN
    ,
    output logic                  out_overflow
`endif
);

    localparam logic [CNT_W-1:0] DW_C = CNT_W'(DATA_WIDTH);

    bsa_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, b_q, sum_q;
    logic [CNT_W-1:0]      cnt_q, n_q, n_eff;
    logic                  carry_q;
    logic                  fa_sum, fa_carry;
    logic                  accept, release_out, last_bit;

    // Zero or oversize widths fall back to the full datapath width.
    assign n_eff       = (cfg_bits == '0 || cfg_bits > DW_C) ? DW_C : cfg_bits;
    assign accept      = in_valid & in_ready;
    assign release_out = out_valid & out_ready;
    assign last_bit    = (cnt_q == n_q - CNT_W'(1));

    full_adder u_cell (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .cin_i  (carry_q),
        .sum_o  (fa_sum),
        .cout_o (fa_carry)
    );

    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (last_bit) state_d = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operands shift right so the cell always sees bit 0; the sum is placed at cnt.
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            n_q     <= '0;
        end else if (accept) begin
            a_q     <= in_a;
            b_q     <= in_b;
            carry_q <= in_cin;
            n_q     <= n_eff;
            cnt_q   <= '0;
        end else if (state_q == ST_RUN) begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            carry_q <= fa_carry;
            sum_q   <= sum_q | (DATA_WIDTH'(fa_sum) << cnt_q);
            cnt_q   <= cnt_q + CNT_W'(1);
        end else if (release_out) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
        end
    end

    assign out_sum   = sum_q;
    assign out_carry = carry_q;

`ifdef BIT_SERIAL_ADD_OVERFLOW_EN
    logic ovf_q;

    // carry_q on the last step is the carry into the top active bit.
    always_ff @(posedge clk) begin
        if (!reset)                              ovf_q <= 1'b0;
        else if (state_q == ST_RUN && last_bit) ovf_q <= carry_q ^ fa_carry;
        else if (release_out)                   ovf_q <= 1'b0;
    end

    assign out_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Directed self-checking bench for bit_serial_add_ctrl (DATA_WIDTH=16).
module tb_bit_serial_add_ctrl;

    localparam int DW = 16;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a, in_b;
    logic          in_cin;
    logic [CW-1:0] cfg_bits;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_sum;
    logic          out_carry;
`ifdef BIT_SERIAL_ADD_OVERFLOW_EN
    logic          out_overflow;
`endif

    int n_cmp = 0;
    int n_err = 0;

    bit_serial_add_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .cfg_bits  (cfg_bits),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry)
`ifdef BIT_SERIAL_ADD_OVERFLOW_EN
        ,
        .out_overflow (out_overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits for out_valid; lat counts cycles from the handshake cycle.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [CW-1:0] cfg,
                          input logic [DW-1:0] a, input logic [DW-1:0] b, input logic cin,
                          input logic [DW-1:0] es, input logic ec, input logic eovf,
                          input int elat);
        int lat;
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; cfg_bits = cfg;
        chk({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0; cfg_bits = 5'd1; in_a = '0; in_b = '0; in_cin = 1'b0;
        wait_out(lat);
        chk({tag, ".latency"}, 32'(lat), 32'(elat));
        chk({tag, ".sum"}, 32'(out_sum), 32'(es));
        chk({tag, ".carry"}, 32'(out_carry), 32'(ec));
        chk({tag, ".in_ready_done"}, 32'(in_ready), 32'd0);
`ifdef BIT_SERIAL_ADD_OVERFLOW_EN
        chk({tag, ".overflow"}, 32'(out_overflow), 32'(eovf));
`else
        if (eovf === 1'bx) $display("unused");
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, ".out_valid_after"}, 32'(out_valid), 32'd0);
        chk({tag, ".in_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int spurious;
        reset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
        cfg_bits = '0; out_ready = 1'b0;
        tick(); tick();
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.out_sum", 32'(out_sum), 32'd0);
        chk("reset.out_carry", 32'(out_carry), 32'd0);
        reset = 1'b1;
        tick();

        run_op("full8",  5'd8,  16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 9);
        run_op("upper4", 5'd4,  16'hFFF3, 16'h0004, 1'b1, 16'h0008, 1'b0, 1'b1, 5);
        run_op("cfg0",   5'd0,  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 17);
        run_op("cfg17",  5'd17, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 17);
        run_op("full16", 5'd16, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 17);
        run_op("n1",     5'd1,  16'hFFFF, 16'hFFFF, 1'b1, 16'h0001, 1'b1, 1'b0, 2);
        run_op("n3",     5'd3,  16'h0005, 16'h0006, 1'b0, 16'h0003, 1'b1, 1'b1, 4);
        run_op("ovf7f",  5'd8,  16'h007F, 16'h0001, 1'b0, 16'h0080, 1'b0, 1'b1, 9);

        // Backpressure with the producer holding its request.
        in_valid = 1'b1; in_a = 16'h003C; in_b = 16'h000F; in_cin = 1'b0; cfg_bits = 5'd8;
        tick();
        wait_out(lat);
        chk("bp.latency", 32'(lat), 32'd9);
        for (int i = 0; i < 5; i++) begin
            chk("bp.sum_hold", 32'(out_sum), 32'h004B);
            chk("bp.valid_hold", 32'(out_valid), 32'd1);
            chk("bp.in_ready_hold", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp.in_ready_release", 32'(in_ready), 32'd1);
        chk("bp.out_valid_release", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        wait_out(lat);
        chk("bp2.latency", 32'(lat), 32'd9);
        chk("bp2.sum", 32'(out_sum), 32'h004B);
        chk("bp2.carry", 32'(out_carry), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset while cnt==3 of an 8-bit op.
        in_valid = 1'b1; in_a = 16'h00AA; in_b = 16'h0055; in_cin = 1'b1; cfg_bits = 5'd8;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("rst_run.in_ready", 32'(in_ready), 32'd1);
        chk("rst_run.out_valid", 32'(out_valid), 32'd0);
        chk("rst_run.out_sum", 32'(out_sum), 32'd0);
        chk("rst_run.out_carry", 32'(out_carry), 32'd0);
        spurious = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) spurious++;
            tick();
        end
        chk("rst_run.no_pulse", 32'(spurious), 32'd0);
        run_op("fresh", 5'd8, 16'h0080, 16'h0080, 1'b1, 16'h0001, 1'b1, 1'b1, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
